ingress_fifo: RTL
=================

Name: ingress_fifo

Overview:
- Per-input-port packet-word queue; one instance per switch input, three per switch.
- Sits directly upstream of the 3x3 output scheduler and drives that scheduler's data/empty inputs for one port.
- Consumes the scheduler's rdreq for that port.
- Show-ahead FIFO: the head word, including its destination field in bits [1:0], is visible before it is popped. The scheduler arbitrates on the head word, then pops it.

Parameters:
- DATA_W, 8: word width. Bits [1:0] are the destination port (00 = no destination/idle, 01..11 = output 1..3).
- DEPTH, 16: number of entries. Must be a power of 2 and at least 4.
- AF_MARGIN, 2: almost_full asserts when free entries <= AF_MARGIN.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst_n, input, 1: synchronous, active-low reset.
- wrreq, input, 1: push wrdata this cycle.
- wrdata, input, DATA_W: word to enqueue.
- full, output, 1: no free entries.
- almost_full, output, 1: free entries <= AF_MARGIN.
- rdreq, input, 1: pop the head word (driven by the scheduler).
- q, output, DATA_W: current head word (show-ahead).
- empty, output, 1: no stored words.
- usedw, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- drop_cnt, output, 16: present only with INGRESS_FIFO_STATS_EN.

Behaviour:
- Reset:
  - When rst_n=0 at posedge clk: wr_ptr=0, rd_ptr=0, usedw=0, empty=1, full=0, almost_full=0, q=0.
  - Any stored contents are discarded; memory contents need not be cleared.
  - Reset mid-operation has the same effect. A wrreq or rdreq in the reset cycle is ignored.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = address bits equal and wrap bits differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Write: wrreq && !full stores wrdata at wr_ptr and increments wr_ptr.
- Write when full: rejected and contents unchanged, even if rdreq pops in the same cycle. Freed space is usable from the next cycle.
- Read:
  - rdreq && !empty increments rd_ptr; q presents the next entry in the following cycle.
  - rdreq while empty is ignored: no pointer change, no underflow. The scheduler's idle path asserts rdreq unconditionally, so this case is normal traffic.
- q output: q = mem[rd_ptr] when !empty, and 0 when empty. A zero word decodes as destination 00, which the scheduler treats as idle.
- Write latency: a word written into an empty FIFO appears on q, with empty=0, one cycle after the write edge.
- Simultaneous push and pop (!empty, !full): both take effect and usedw is unchanged.
- Status flags: usedw, full and almost_full are registered and valid in the same cycle as the pointer update. They are derived from the post-update pointers.
- Memory: no read-during-write hazard. A write is never to rd_ptr while !empty, except when the FIFO is full, and full writes are rejected.

Optional Feature:
- Macro: INGRESS_FIFO_STATS_EN.
- With the macro defined:
  - drop_cnt port exists; reset to 0.
  - Increments by 1 on each cycle with wrreq && full.
  - Saturates at 16'hFFFF.
- Without the macro: the drop_cnt port and counter are absent, and rejected writes are silently discarded.

Decomposition:
- Package switch_pkg holds:
  - localparam PORT_W=2;
  - typedef logic [PORT_W-1:0] port_id_t;
  - constants PORT_NONE=2'b00, PORT_1=2'b01, PORT_2=2'b10, PORT_3=2'b11;
  - default DATA_W=8.
- Sub-module fifo_mem:
  - DEPTH x DATA_W simple dual-port storage.
  - Synchronous write, asynchronous read.
  - No reset.
- ingress_fifo holds the pointers, flags, q muxing and the stats counter.

Test Plan:
- Reset then idle, rdreq=1 for 5 cycles -> empty=1, q=0, usedw=0 throughout, no pointer movement.
- Write 8'h05, 8'h0A, 8'h0F on consecutive cycles with rdreq=0:
  - empty deasserts the cycle after the first write, with q=8'h05;
  - usedw reaches 3.
  - Then rdreq=1 for 3 cycles -> q steps 05, 0A, 0F, then 0 with empty=1.
- Fill to 16 entries:
  - almost_full=1 at usedw=14, full=1 at usedw=16.
  - A 17th wrreq with simultaneous rdreq -> write rejected, usedw=15; with STATS_EN, drop_cnt=1.
- Steady push+pop for 40 cycles at usedw=4 -> usedw stays 4, pointers wrap past 2*DEPTH, output order equals input order.
- Assert rst_n=0 for one cycle with usedw=9, wrreq=1 and rdreq=1 -> next cycle usedw=0, empty=1, full=0, q=0.
- Three instances connected to the scheduler, head words 8'h01, 8'h01 and 8'h02 -> instance 1 pops; instance 2 holds 8'h01 (no pop); instance 3 pops.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch definitions: destination port encoding carried in word bits [1:0]
// and the default datapath width used by the ingress queues.
package switch_pkg;

    localparam int PORT_W = 2;

    typedef logic [PORT_W-1:0] port_id_t;

    localparam port_id_t PORT_NONE = 2'b00;
    localparam port_id_t PORT_1    = 2'b01;
    localparam port_id_t PORT_2    = 2'b10;
    localparam port_id_t PORT_3    = 2'b11;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/ingress_fifo_if.sv
// Write/read bus between a switch input, its ingress queue and the output scheduler.
// drop_cnt is carried only when INGRESS_FIFO_STATS_EN is defined.
interface ingress_fifo_if
    import switch_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 16
);

    logic                   wrreq;
    logic [DATA_W-1:0]      wrdata;
    logic                   full;
    logic                   almost_full;
    logic                   rdreq;
    logic [DATA_W-1:0]      q;
    logic                   empty;
    logic [$clog2(DEPTH):0] usedw;
`ifdef INGRESS_FIFO_STATS_EN
    logic [15:0]            drop_cnt;

    modport master (output wrreq, wrdata, rdreq,
                    input  full, almost_full, q, empty, usedw, drop_cnt);
    modport slave  (input  wrreq, wrdata, rdreq,
                    output full, almost_full, q, empty, usedw, drop_cnt);
`else
    modport master (output wrreq, wrdata, rdreq,
                    input  full, almost_full, q, empty, usedw);
    modport slave  (input  wrreq, wrdata, rdreq,
                    output full, almost_full, q, empty, usedw);
`endif

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ingress_fifo.sv
// Show-ahead per-port ingress queue feeding the output scheduler; all outputs registered.
// Optional drop statistics counter enabled by INGRESS_FIFO_STATS_EN.
module ingress_fifo
    import switch_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ingress_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_MARGIN);

    logic [PW-1:0]     wr_ptr_r, rd_ptr_r, usedw_r;
    logic [PW-1:0]     wr_ptr_s, rd_ptr_s, usedw_s;
    logic              full_r, empty_r, af_r;
    logic              full_s, empty_s, af_s;
    logic              wr_en_s, rd_en_s;
    logic [DATA_W-1:0] q_r, q_s, rd_data_s;

    // The memory is read at the post-update head so q can be registered.
    fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (bus.wrdata),
        .raddr (rd_ptr_s[AW-1:0]),
        .rdata (rd_data_s)
    );

    // Next-state pointers, flags and head word
    always_comb begin
        wr_en_s = bus.wrreq && !full_r;
        rd_en_s = bus.rdreq && !empty_r;
        if (wr_en_s) begin
            wr_ptr_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (rd_en_s) begin
            rd_ptr_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        usedw_s = wr_ptr_s - rd_ptr_s;
        empty_s = (wr_ptr_s == rd_ptr_s);
        full_s  = (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]) && (wr_ptr_s[AW] != rd_ptr_s[AW]);
        af_s    = (DEPTH_P - usedw_s) <= AF_P;
        // A write landing on the new head only happens when it is the sole entry: forward it.
        if (empty_s) begin
            q_s = {DATA_W{1'b0}};
        end else if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_ptr_s[AW-1:0])) begin
            q_s = bus.wrdata;
        end else begin
            q_s = rd_data_s;
        end
    end

    // Pointer and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            usedw_r  <= {PW{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            af_r     <= 1'b0;
            q_r      <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            usedw_r  <= usedw_s;
            empty_r  <= empty_s;
            full_r   <= full_s;
            af_r     <= af_s;
            q_r      <= q_s;
        end
    end

    assign bus.q           = q_r;
    assign bus.empty       = empty_r;
    assign bus.full        = full_r;
    assign bus.almost_full = af_r;
    assign bus.usedw       = usedw_r;

`ifdef INGRESS_FIFO_STATS_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of writes rejected because the queue was full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_r <= 16'h0000;
        end else if (bus.wrreq && full_r && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign bus.drop_cnt = drop_cnt_r;
`endif

endmodule
